// File: rtl/mismatch_ref_gen_if.sv
// Stream/reference bundle between the mismatch reference generator and its neighbours.
// master = stimulus/equaliser side, slave = mismatch_ref_gen.
interface mismatch_ref_gen_if;
  logic               start;
  logic signed [15:0] xr_in;
  logic signed [15:0] xi_in;
  logic signed [15:0] yr;
  logic signed [15:0] yi;
  logic               clkdv;
  logic signed [15:0] xr;
  logic signed [15:0] xi;
  logic signed [15:0] rr;
  logic signed [15:0] ri;
  logic               training;
  logic               dd_mode;

  modport master (
    output start, xr_in, xi_in, yr, yi,
    input  clkdv, xr, xi, rr, ri, training, dd_mode
  );

  modport slave (
    input  start, xr_in, xi_in, yr, yi,
    output clkdv, xr, xi, rr, ri, training, dd_mode
  );
endinterface

// File: rtl/mismatch_ref_gen.sv
// Symbol-rate sampler and QPSK training/decision reference source for the mismatch equaliser.
// Optional decision-directed mode after training: define MISMATCH_REF_DD_EN.
module mismatch_ref_gen #(
  parameter logic signed [15:0] AMP       = 16'sd11585,
  parameter int                 TRAIN_LEN = 1024,
  parameter int                 DELAY     = 4
) (
  input  logic             clk,
  input  logic             rst,
  mismatch_ref_gen_if.slave bus
);

  // state   | meaning
  // S_IDLE  | sampling only, reference held at zero
  // S_TRAIN | PN training symbols through the delay line
  // S_DD    | reference from sign decisions on yr/yi
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAIN = 2'd1,
    S_DD    = 2'd2
  } state_t;

  localparam logic signed [15:0] NEG_AMP = -AMP;
  localparam logic [6:0]         SEED    = 7'h7F;
  localparam int                 DLEN    = (DELAY > 0) ? DELAY : 1;
  localparam logic [15:0]        TLEN16  = 16'(TRAIN_LEN);

  function automatic logic [6:0] lfsr_step(input logic [6:0] l);
    return {l[5:0], l[6] ^ l[5]};
  endfunction

  state_t                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     clkdv_q;
  logic [6:0]               lfsr_q, lfsr_d, lfsr_src;
  logic [15:0]              scnt_q, scnt_d;
  logic                     pend_q, pend_d;
  logic [DLEN-1:0][31:0]    dl_q, dl_d, dl_base;
  logic signed [15:0]       xr_q, xr_d, xi_q, xi_d;
  logic signed [15:0]       rr_q, rr_d, ri_q, ri_d;
  logic signed [15:0]       sym_re, sym_im;
  logic                     wrap, go, emit;

  assign cnt_d    = cnt_q + 3'd1;
  assign wrap     = (cnt_q == 3'd7);
  assign go       = wrap & (pend_q | bus.start);
  // A restart emits the seed symbol into a freshly cleared delay line on the same wrap.
  assign lfsr_src = go ? SEED : lfsr_q;
  assign dl_base  = go ? '0 : dl_q;
  assign sym_re   = lfsr_src[0] ? NEG_AMP : AMP;
  assign sym_im   = lfsr_src[1] ? NEG_AMP : AMP;

`ifdef MISMATCH_REF_DD_EN
  logic signed [15:0] dec_re, dec_im;
  assign dec_re = bus.yr[15] ? NEG_AMP : AMP;
  assign dec_im = bus.yi[15] ? NEG_AMP : AMP;
`else
  logic unused_dd_inputs;
  assign unused_dd_inputs = ^{bus.yr, bus.yi};
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    scnt_d  = scnt_q;
    pend_d  = pend_q;
    dl_d    = dl_q;
    xr_d    = xr_q;
    xi_d    = xi_q;
    rr_d    = rr_q;
    ri_d    = ri_q;
    emit    = 1'b0;

    if (bus.start) pend_d = 1'b1;

    if (wrap) begin
      xr_d = bus.xr_in;
      xi_d = bus.xi_in;
      if (go) begin
        pend_d  = 1'b0;
        state_d = S_TRAIN;
        emit    = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            rr_d = '0;
            ri_d = '0;
          end
          S_TRAIN: begin
`ifdef MISMATCH_REF_DD_EN
            if (scnt_q == TLEN16) begin
              state_d = S_DD;
              rr_d    = dec_re;
              ri_d    = dec_im;
            end else begin
              emit = 1'b1;
            end
`else
            emit = 1'b1;
`endif
          end
`ifdef MISMATCH_REF_DD_EN
          S_DD: begin
            rr_d = dec_re;
            ri_d = dec_im;
          end
`endif
          default: state_d = S_IDLE;
        endcase
      end
    end

    if (emit) begin
      lfsr_d   = lfsr_step(lfsr_src);
      dl_d[0]  = {sym_re, sym_im};
      for (int i = 1; i < DLEN; i++) dl_d[i] = dl_base[i-1];
      if (DELAY == 0) begin
        rr_d = sym_re;
        ri_d = sym_im;
      end else begin
        rr_d = dl_base[DLEN-1][31:16];
        ri_d = dl_base[DLEN-1][15:0];
      end
      if (go)                    scnt_d = 16'd1;
      else if (scnt_q != TLEN16) scnt_d = scnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      clkdv_q <= 1'b0;
      lfsr_q  <= SEED;
      scnt_q  <= '0;
      pend_q  <= 1'b0;
      dl_q    <= '0;
      xr_q    <= '0;
      xi_q    <= '0;
      rr_q    <= '0;
      ri_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clkdv_q <= cnt_d[2];
      lfsr_q  <= lfsr_d;
      scnt_q  <= scnt_d;
      pend_q  <= pend_d;
      dl_q    <= dl_d;
      xr_q    <= xr_d;
      xi_q    <= xi_d;
      rr_q    <= rr_d;
      ri_q    <= ri_d;
    end
  end

  assign bus.clkdv    = clkdv_q;
  assign bus.xr       = xr_q;
  assign bus.xi       = xi_q;
  assign bus.rr       = rr_q;
  assign bus.ri       = ri_q;
  assign bus.training = (state_q == S_TRAIN);
`ifdef MISMATCH_REF_DD_EN
  assign bus.dd_mode  = (state_q == S_DD);
`else
  assign bus.dd_mode  = 1'b0;
`endif

endmodule

// File: tb/tb_mismatch_ref_gen.sv
// Directed bench for mismatch_ref_gen: dut_a uses DELAY=4/TRAIN_LEN=1024, dut_b DELAY=0/TRAIN_LEN=8.
module tb_mismatch_ref_gen;
  localparam logic signed [15:0] AMP  = 16'sd11585;
  localparam logic signed [15:0] NAMP = -16'sd11585;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] tb_cnt;
  int n_checks = 0;
  int n_pass   = 0;

  mismatch_ref_gen_if bus_a();
  mismatch_ref_gen_if bus_b();

  mismatch_ref_gen #(.AMP(AMP), .TRAIN_LEN(1024), .DELAY(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  mismatch_ref_gen #(.AMP(AMP), .TRAIN_LEN(8), .DELAY(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // Expected phase of the symbol counter, restarted by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 3'd0;
    else     tb_cnt <= tb_cnt + 3'd1;
  end

  function automatic logic [6:0] m_step(input logic [6:0] l);
    return {l[5:0], l[6] ^ l[5]};
  endfunction

  function automatic logic signed [15:0] m_sym(input logic b);
    return b ? NAMP : AMP;
  endfunction

  task automatic next_wrap();
    bit w;
    w = 1'b0;
    while (!w) begin
      @(posedge clk);
      w = (tb_cnt == 3'd7);
    end
    #1;
  endtask

  task automatic pulse_start_a();
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
  endtask

  task automatic pulse_start_b();
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (bus_a.clkdv !== 1'b0) $display("FAIL reset_clkdv: got %b want 0", bus_a.clkdv); else n_pass++;
    n_checks++; if (bus_a.xr !== 16'sd0 || bus_a.xi !== 16'sd0) $display("FAIL reset_x: got %0d,%0d want 0,0", bus_a.xr, bus_a.xi); else n_pass++;
    n_checks++; if (bus_a.rr !== 16'sd0 || bus_a.ri !== 16'sd0) $display("FAIL reset_r: got %0d,%0d want 0,0", bus_a.rr, bus_a.ri); else n_pass++;
    n_checks++; if (bus_a.training !== 1'b0 || bus_a.dd_mode !== 1'b0) $display("FAIL reset_mode: got %b%b want 00", bus_a.training, bus_a.dd_mode); else n_pass++;
    n_checks++; if (bus_b.training !== 1'b0 || bus_b.rr !== 16'sd0) $display("FAIL reset_b: got tr=%b rr=%0d want 0,0", bus_b.training, bus_b.rr); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    logic signed [15:0] exp_xr, exp_xi;
    exp_xr = 16'sd0;
    exp_xi = 16'sd0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk); #1;
      if (tb_cnt == 3'd0) begin
        exp_xr = bus_a.xr_in;
        exp_xi = bus_a.xi_in;
      end
      n_checks++; if (bus_a.clkdv !== tb_cnt[2]) $display("FAIL idle_clkdv c=%0d: got %b want %b", c, bus_a.clkdv, tb_cnt[2]); else n_pass++;
      n_checks++; if (bus_a.xr !== exp_xr || bus_a.xi !== exp_xi) $display("FAIL idle_x c=%0d: got %0d,%0d want %0d,%0d", c, bus_a.xr, bus_a.xi, exp_xr, exp_xi); else n_pass++;
      n_checks++; if (bus_a.rr !== 16'sd0 || bus_a.training !== 1'b0) $display("FAIL idle_r c=%0d: got rr=%0d tr=%b want 0,0", c, bus_a.rr, bus_a.training); else n_pass++;
      if (tb_cnt == 3'd2) begin
        bus_a.xr_in = 16'(c * 517 - 9000);
        bus_a.xi_in = 16'(12000 - c * 311);
      end
    end
  endtask

  task automatic test_train_d0();
    logic signed [15:0] exp_re [3];
    logic signed [15:0] exp_im [3];
    exp_re = '{NAMP, AMP, AMP};
    exp_im = '{NAMP, NAMP, AMP};
    bus_b.yr = -16'sd5;
    bus_b.yi = 16'sd3;
    pulse_start_b();
    n_checks++; if (bus_b.training !== 1'b0) $display("FAIL d0_pre_wrap_training: got %b want 0", bus_b.training); else n_pass++;
    next_wrap();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (bus_b.training !== 1'b1) $display("FAIL d0_training k=%0d: got %b want 1", k, bus_b.training); else n_pass++;
      n_checks++; if (bus_b.rr !== exp_re[k] || bus_b.ri !== exp_im[k]) $display("FAIL d0_sym k=%0d: got %0d,%0d want %0d,%0d", k, bus_b.rr, bus_b.ri, exp_re[k], exp_im[k]); else n_pass++;
      if (k < 2) next_wrap();
    end
  endtask

  task automatic test_tlen();
    logic [6:0] l;
    repeat (6) next_wrap();
`ifdef MISMATCH_REF_DD_EN
    l = 7'h7F;
    n_checks++; if (bus_b.dd_mode !== 1'b1 || bus_b.training !== 1'b0) $display("FAIL dd_entry_mode: got dd=%b tr=%b want 1,0", bus_b.dd_mode, bus_b.training); else n_pass++;
    n_checks++; if (bus_b.rr !== NAMP || bus_b.ri !== AMP) $display("FAIL dd_entry_ref: got %0d,%0d want %0d,%0d", bus_b.rr, bus_b.ri, NAMP, AMP); else n_pass++;
    bus_b.yr = 16'sd7;
    bus_b.yi = -16'sd2;
    next_wrap();
    n_checks++; if (bus_b.rr !== AMP || bus_b.ri !== NAMP || bus_b.dd_mode !== 1'b1) $display("FAIL dd_decide: got %0d,%0d dd=%b want %0d,%0d,1", bus_b.rr, bus_b.ri, bus_b.dd_mode, AMP, NAMP); else n_pass++;
`else
    l = 7'h7F;
    repeat (8) l = m_step(l);
    n_checks++; if (bus_b.training !== 1'b1 || bus_b.dd_mode !== 1'b0) $display("FAIL notrain_exit: got tr=%b dd=%b want 1,0", bus_b.training, bus_b.dd_mode); else n_pass++;
    n_checks++; if (bus_b.rr !== m_sym(l[0]) || bus_b.ri !== m_sym(l[1])) $display("FAIL sym8: got %0d,%0d want %0d,%0d", bus_b.rr, bus_b.ri, m_sym(l[0]), m_sym(l[1])); else n_pass++;
`endif
  endtask

  task automatic test_train_d4();
    logic [6:0] l;
    logic signed [15:0] er, ei;
    l = 7'h7F;
    pulse_start_a();
    next_wrap();
    for (int k = 0; k < 135; k++) begin
      if (k < 4) begin
        er = 16'sd0;
        ei = 16'sd0;
      end else begin
        er = m_sym(l[0]);
        ei = m_sym(l[1]);
        l  = m_step(l);
      end
      n_checks++; if (bus_a.rr !== er || bus_a.ri !== ei || bus_a.training !== 1'b1) $display("FAIL d4_sym k=%0d: got %0d,%0d tr=%b want %0d,%0d,1", k, bus_a.rr, bus_a.ri, bus_a.training, er, ei); else n_pass++;
      if (k == 131) begin
        n_checks++; if (bus_a.rr !== NAMP || bus_a.ri !== NAMP) $display("FAIL d4_period127: got %0d,%0d want %0d,%0d", bus_a.rr, bus_a.ri, NAMP, NAMP); else n_pass++;
      end
      next_wrap();
    end
  endtask

  task automatic test_restart();
    logic signed [15:0] er [6];
    logic signed [15:0] ei [6];
    er = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, NAMP, AMP};
    ei = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, NAMP, NAMP};
    pulse_start_a();
    next_wrap();
    repeat (50) next_wrap();
    n_checks++; if (bus_a.rr === 16'sd0) $display("FAIL restart_pre: got rr=%0d want nonzero", bus_a.rr); else n_pass++;
    pulse_start_a();
    next_wrap();
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (bus_a.rr !== er[k] || bus_a.ri !== ei[k] || bus_a.training !== 1'b1) $display("FAIL restart_sym k=%0d: got %0d,%0d tr=%b want %0d,%0d,1", k, bus_a.rr, bus_a.ri, bus_a.training, er[k], ei[k]); else n_pass++;
      if (k < 5) next_wrap();
    end
  endtask

  task automatic test_start_on_wrap();
    int guard;
    guard = 0;
    while (tb_cnt != 3'd7 && guard < 16) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++; if (tb_cnt !== 3'd7) $display("FAIL wrap_align: got %0d want 7", tb_cnt); else n_pass++;
    bus_b.start = 1'b1;
    next_wrap();
    bus_b.start = 1'b0;
    n_checks++; if (bus_b.training !== 1'b1 || bus_b.dd_mode !== 1'b0) $display("FAIL coinc_mode: got tr=%b dd=%b want 1,0", bus_b.training, bus_b.dd_mode); else n_pass++;
    n_checks++; if (bus_b.rr !== NAMP || bus_b.ri !== NAMP) $display("FAIL coinc_seed: got %0d,%0d want %0d,%0d", bus_b.rr, bus_b.ri, NAMP, NAMP); else n_pass++;
    next_wrap();
    n_checks++; if (bus_b.rr !== AMP || bus_b.ri !== NAMP) $display("FAIL coinc_sym1: got %0d,%0d want %0d,%0d", bus_b.rr, bus_b.ri, AMP, NAMP); else n_pass++;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (tb_cnt != 3'd5 && guard < 16) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++; if (bus_a.clkdv !== 1'b1) $display("FAIL pre_rst_clkdv: got %b want 1", bus_a.clkdv); else n_pass++;
    #2;
    rst = 1'b1;
    bus_a.start = 1'b1;
    #1;
    n_checks++; if (bus_a.clkdv !== 1'b0 || bus_a.training !== 1'b0 || bus_a.dd_mode !== 1'b0) $display("FAIL rst_ctrl: got clkdv=%b tr=%b dd=%b want 000", bus_a.clkdv, bus_a.training, bus_a.dd_mode); else n_pass++;
    n_checks++; if (bus_a.xr !== 16'sd0 || bus_a.xi !== 16'sd0 || bus_a.rr !== 16'sd0 || bus_a.ri !== 16'sd0) $display("FAIL rst_data: got %0d,%0d,%0d,%0d want 0,0,0,0", bus_a.xr, bus_a.xi, bus_a.rr, bus_a.ri); else n_pass++;
    n_checks++; if (bus_b.training !== 1'b0 || bus_b.rr !== 16'sd0) $display("FAIL rst_b: got tr=%b rr=%0d want 0,0", bus_b.training, bus_b.rr); else n_pass++;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_a.xr_in = 16'sd1234;
    bus_a.xi_in = -16'sd4321;
    next_wrap();
    n_checks++; if (bus_a.training !== 1'b0 || bus_a.rr !== 16'sd0) $display("FAIL rst_start_ignored: got tr=%b rr=%0d want 0,0", bus_a.training, bus_a.rr); else n_pass++;
    n_checks++; if (bus_a.xr !== 16'sd1234 || bus_a.xi !== -16'sd4321) $display("FAIL rst_first_sample: got %0d,%0d want 1234,-4321", bus_a.xr, bus_a.xi); else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      n_checks++; if (bus_a.clkdv !== (c == 4)) $display("FAIL rst_clkdv_rise c=%0d: got %b want %b", c, bus_a.clkdv, (c == 4)); else n_pass++;
    end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.xr_in = '0; bus_a.xi_in = '0; bus_a.yr = '0; bus_a.yi = '0;
    bus_b.start = 1'b0; bus_b.xr_in = '0; bus_b.xi_in = '0; bus_b.yr = '0; bus_b.yi = '0;
    test_reset();
    test_idle();
    test_train_d0();
    test_tlen();
    test_train_d4();
    test_restart();
    test_start_on_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mismatch_ref_gen.md
# mismatch_ref_gen

Upstream feeder for the adaptive complex mismatch equaliser. It samples the incoming complex stream once per 8-clock symbol period and holds it stable for the equaliser. It generates the matching known QPSK training reference from a PN sequence, delay-aligned to the channel latency, and produces the divide-by-8 data clock. Optionally, after training it switches to decision-directed reference generation from the equaliser's outputs.

## Interface
Parameters:
- AMP, 16'sd11585, reference symbol magnitude per rail (≈0.707 in Q1.14)
- TRAIN_LEN, 1024, training length in symbols (1..65535)
- DELAY, 4, reference delay in symbols (0..15), matching the channel latency

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-clock pulse that (re)starts training
- xr_in, xi_in  in  16 signed  received sample, real/imag, valid at symbol rate
- yr, yi  in  16 signed  equaliser output, used only in decision-directed mode
- clkdv  out  1  symbol clock, clk/8, 50% duty
- xr, xi  out  16 signed  held input sample to the equaliser
- rr, ri  out  16 signed  held reference to the equaliser
- training  out  1  high while in TRAIN
- dd_mode  out  1  high while in DD; tied 0 when the feature is compiled out

## Operation
- 3-bit phase counter `cnt` is free-running from reset. A symbol boundary ("wrap") is the clk edge on which `cnt` goes 7→0.
- Registered output `clkdv <= cnt_next[2]`: low for cnt 0..3, high for cnt 4..7.
- At each wrap, `xr`/`xi` load `xr_in`/`xi_in`. This happens in every state, including IDLE.
- PN source: 7-bit Fibonacci LFSR, x^7+x^6+1.
  - Seed 7'h7F.
  - Step: `lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}`.
  - Period 127.
- Training symbol from the current LFSR state:
  - re = lfsr[0] ? −AMP : +AMP
  - im = lfsr[1] ? −AMP : +AMP
- Delay line: DELAY-deep shift register of {re,im} pairs. It shifts at each wrap while in TRAIN and is cleared to zeros on entry to TRAIN. `rr`/`ri` load from the delay output at each wrap. With DELAY=0 the symbol goes directly to `rr`/`ri`.
- FSM states:
  - IDLE: `rr=ri=0`; `training=0`.
  - TRAIN: emit one symbol per wrap, then step the LFSR. Symbol counter `scnt` counts emitted symbols.
  - DD (macro only): see Configuration.
- Transitions:
  - A `start` pulse sets a pending flag.
  - At the next wrap with the flag set: enter TRAIN, LFSR=seed, `scnt=0`, delay line zeroed, flag cleared. The symbol from the seed is emitted on that same wrap.
  - A `start` during TRAIN or DD restarts training identically.
  - TRAIN→DD at the wrap after symbol TRAIN_LEN−1 has been emitted, if the macro is defined.
- Width rules:
  - `scnt` is 16 bits.
  - Inputs pass through unmodified; no arithmetic on the data path.
  - `yr`/`yi` sign test: the value is treated as non-negative when bit 15 = 0.

## Timing
- Reset values: `cnt=0`, `clkdv=0`, `xr=xi=rr=ri=0`, `training=0`, `dd_mode=0`, LFSR=7'h7F, state IDLE, pending flag clear, delay line zero.
- `xr/xi/rr/ri` change only on wrap edges. They are stable for 8 clocks and settled 4 clocks before each `clkdv` rising edge.
- `start` to `training=1`: state and `training` go high on the first wrap after the pulse, i.e. 1..8 clocks later.
- Reference latency: symbol k (k=0 at TRAIN entry) appears on `rr`/`ri` at wrap k+DELAY. Before that, `rr`/`ri` output zeros.
- `start` coincident with a wrap: takes effect on that wrap.
- Asynchronous `rst` mid-operation: all state returns to reset values immediately. `start` pulses during reset are ignored.

## Configuration
- MISMATCH_REF_DD_EN defined:
  - After TRAIN_LEN symbols, the FSM enters DD and `dd_mode=1`.
  - At each wrap: `rr <= yr[15] ? −AMP : +AMP`, `ri <= yi[15] ? −AMP : +AMP`, using the equaliser outputs present at that wrap, without the delay line.
  - DD persists until `start` or `rst`.
- MISMATCH_REF_DD_EN undefined:
  - TRAIN never exits; the LFSR free-runs, repeating every 127 symbols.
  - `scnt` saturates at TRAIN_LEN; `dd_mode` is constant 0; the `yr`/`yi` inputs are unused.

## Test plan
- Reset then idle 64 clocks → `clkdv` toggles every 4 clocks starting low; `rr=ri=0`; `xr/xi` track `xr_in/xi_in`, updated only on wraps.
- DELAY=0, pulse `start` → first three training symbols on `rr/ri` are (−11585,−11585), (+11585,−11585), (+11585,+11585), one per 8 clocks; `training=1`.
- DELAY=4, `start` → 4 symbols of (0,0), then the same sequence as the previous test; the sequence repeats with period 127 symbols.
- TRAIN_LEN=8 with macro, `yr=−5`, `yi=+3` → after 8 symbols `dd_mode=1`, `training=0`, `rr=−11585`, `ri=+11585`. Without macro → `training` stays 1 indefinitely.
- `start` mid-training at symbol 50 → at the next wrap, the emitted symbol is the seed symbol (−AMP,−AMP) and the delay line is flushed to zeros.
- Assert `rst` mid-symbol (cnt=5) → all outputs 0 immediately; after release, `clkdv` rises 4 clocks after the first wrap.
